// File: rtl/wb_ctrl.sv
// wb_ctrl: writeback source select, load wait with timeout, one rf write per retired pc
module wb_ctrl #(
  parameter int PW = 4,
  parameter int MEM_TMO = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  input  logic [11:0]   prog_ctr,
  input  logic [1:0]    wb_sel,
  input  logic [PW-1:0] dest,
  input  logic [7:0]    alu_res,
  input  logic [7:0]    imm,
  input  logic          mem_rd_valid,
  input  logic [7:0]    mem_rd_data,
  output logic          rf_wr_en,
  output logic [PW-1:0] rf_wr_addr,
  output logic [7:0]    rf_dat_in,
  output logic          stall,
  output logic          mem_err,
  output logic [15:0]   wb_count
);
  typedef enum logic {IDLE, WAIT_MEM} state_t;
  state_t state, nxt_state;
  logic [11:0] last_pc;
  logic [7:0] timer;
  logic [PW-1:0] dest_q;
  logic acc, tmo, wr, nxt_err;
  logic [PW-1:0] nxt_addr;
  logic [7:0] nxt_data;
  assign acc = state == IDLE && instr_valid && prog_ctr != last_pc;
  assign tmo = timer == 8'(MEM_TMO - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_pc <= 12'hFFF;
      timer <= '0;
      dest_q <= '0;
      rf_wr_en <= 1'b0;
      rf_wr_addr <= '0;
      rf_dat_in <= '0;
      stall <= 1'b0;
      mem_err <= 1'b0;
      wb_count <= '0;
    end else begin
      state <= nxt_state;
      if (acc) last_pc <= prog_ctr;
      if (acc && wb_sel == 2'b01) dest_q <= dest;
      timer <= state == IDLE ? '0 : timer + 8'd1;
      rf_wr_en <= wr;
      rf_wr_addr <= nxt_addr;
      rf_dat_in <= nxt_data;
      stall <= nxt_state == WAIT_MEM;
      mem_err <= nxt_err;
      if (wr) wb_count <= wb_count + 16'd1;
    end
  end
  always_comb begin
    nxt_state = state;
    if (state == IDLE) nxt_state = acc && wb_sel == 2'b01 ? WAIT_MEM : IDLE;
    else nxt_state = mem_rd_valid || tmo ? IDLE : WAIT_MEM;
  end
  always_comb begin
    wr = (acc && !wb_sel[0]) || (state == WAIT_MEM && mem_rd_valid);
    nxt_addr = !wr ? rf_wr_addr : state == WAIT_MEM ? dest_q : dest;
    nxt_data = !wr ? rf_dat_in : state == WAIT_MEM ? mem_rd_data : wb_sel[1] ? imm : alu_res;
    nxt_err = mem_err || (state == WAIT_MEM && !mem_rd_valid && tmo);
  end
endmodule

// File: tb/tb_wb_ctrl.sv
// tb_wb_ctrl: directed and random checks of wb_ctrl against a transaction-level model
module tb_wb_ctrl;
  localparam int MEM_TMO = 8;
  logic clk = 1'b0;
  logic reset;
  logic instr_valid;
  logic [11:0] prog_ctr;
  logic [1:0] wb_sel;
  logic [3:0] dest;
  logic [7:0] alu_res, imm, mem_rd_data;
  logic mem_rd_valid;
  logic rf_wr_en, stall, mem_err;
  logic [3:0] rf_wr_addr;
  logic [7:0] rf_dat_in;
  logic [15:0] wb_count;
  int total = 0;
  int bad = 0;
  logic [11:0] m_last;
  logic m_busy, m_en, m_stall, m_err;
  int m_wait;
  logic [3:0] m_pend, m_addr;
  logic [7:0] m_data;
  logic [15:0] m_cnt;
  int pulses;

  wb_ctrl #(.PW(4), .MEM_TMO(MEM_TMO)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .prog_ctr(prog_ctr),
    .wb_sel(wb_sel), .dest(dest), .alu_res(alu_res), .imm(imm),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_dat_in(rf_dat_in),
    .stall(stall), .mem_err(mem_err), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    m_en = 1'b1;
    m_addr = a;
    m_data = d;
    m_cnt = m_cnt + 16'd1;
  endtask

  task automatic drv(input logic iv, input logic [11:0] pc, input logic [1:0] sel,
                     input logic [3:0] d, input logic [7:0] a, input logic [7:0] im,
                     input logic mv, input logic [7:0] md);
    instr_valid = iv; prog_ctr = pc; wb_sel = sel; dest = d;
    alu_res = a; imm = im; mem_rd_valid = mv; mem_rd_data = md;
  endtask

  task automatic idle();
    drv(1'b0, 12'h0, 2'b11, 4'h0, 8'h0, 8'h0, 1'b0, 8'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_last = 12'hFFF; m_busy = 1'b0; m_wait = 0; m_pend = '0;
      m_en = 1'b0; m_addr = '0; m_data = '0; m_stall = 1'b0; m_err = 1'b0; m_cnt = '0;
    end else begin
      m_en = 1'b0;
      if (m_busy) begin
        m_wait++;
        if (mem_rd_valid) begin
          m_busy = 1'b0;
          wr(m_pend, mem_rd_data);
        end else if (m_wait == MEM_TMO) begin
          m_busy = 1'b0;
          m_err = 1'b1;
        end
      end else if (instr_valid && prog_ctr != m_last) begin
        m_last = prog_ctr;
        if (wb_sel == 2'b00) wr(dest, alu_res);
        else if (wb_sel == 2'b10) wr(dest, imm);
        else if (wb_sel == 2'b01) begin
          m_busy = 1'b1; m_wait = 0; m_pend = dest;
        end
      end
      m_stall = m_busy;
    end
    #1;
    if (rf_wr_en) pulses++;
    chk("wr_en", rf_wr_en, m_en);
    chk("wr_addr", rf_wr_addr, m_addr);
    chk("dat_in", rf_dat_in, m_data);
    chk("stall", stall, m_stall);
    chk("mem_err", mem_err, m_err);
    chk("wb_count", wb_count, m_cnt);
  endtask

  initial begin
    int p0;
    reset = 1'b1;
    idle();
    tick(); tick();
    chk("rst_wr_en", rf_wr_en, 0);
    chk("rst_count", wb_count, 0);
    chk("rst_stall", stall, 0);
    reset = 1'b0;
    drv(1'b1, 12'h000, 2'b00, 4'd3, 8'h5A, 8'h00, 1'b0, 8'h00); tick();
    chk("alu_en", rf_wr_en, 1); chk("alu_addr", rf_wr_addr, 3);
    chk("alu_data", rf_dat_in, 8'h5A); chk("alu_cnt", wb_count, 1);
    idle(); tick();
    chk("alu_pulse_end", rf_wr_en, 0);
    p0 = pulses;
    drv(1'b1, 12'h005, 2'b10, 4'd4, 8'h00, 8'h11, 1'b0, 8'h00);
    repeat (4) tick();
    idle(); tick();
    chk("dup_pulses", pulses - p0, 1);
    chk("dup_cnt", wb_count, 2);
    for (int i = 1; i <= 3; i++) begin
      drv(1'b1, 12'(i), 2'b00, 4'(i), 8'(i), 8'h00, 1'b0, 8'h00); tick();
      chk("b2b_en", rf_wr_en, 1); chk("b2b_addr", rf_wr_addr, i); chk("b2b_data", rf_dat_in, i);
    end
    drv(1'b1, 12'h00A, 2'b01, 4'd7, 8'h00, 8'h00, 1'b0, 8'h00); tick();
    chk("ld_stall0", stall, 1);
    for (int i = 0; i < 2; i++) begin
      drv(1'b1, 12'h00A, 2'b01, 4'd7, 8'h00, 8'h00, 1'b0, 8'h00); tick();
      chk("ld_stall", stall, 1);
    end
    drv(1'b1, 12'h00A, 2'b01, 4'd7, 8'h00, 8'h00, 1'b1, 8'hC3); tick();
    chk("ld_en", rf_wr_en, 1); chk("ld_addr", rf_wr_addr, 7);
    chk("ld_data", rf_dat_in, 8'hC3); chk("ld_stall_drop", stall, 0);
    drv(1'b1, 12'h00B, 2'b00, 4'd2, 8'h77, 8'h00, 1'b0, 8'h00); tick();
    chk("ld_next_en", rf_wr_en, 1); chk("ld_next_data", rf_dat_in, 8'h77);
    p0 = pulses;
    drv(1'b1, 12'h014, 2'b01, 4'd9, 8'h00, 8'h00, 1'b0, 8'h00); tick();
    for (int i = 1; i <= MEM_TMO; i++) begin
      idle(); tick();
      chk("tmo_stall", stall, i < MEM_TMO);
      chk("tmo_err", mem_err, i == MEM_TMO);
    end
    drv(1'b0, 12'h0, 2'b11, 4'h0, 8'h0, 8'h0, 1'b1, 8'hEE); tick();
    idle(); tick();
    chk("tmo_no_write", pulses - p0, 0);
    chk("tmo_sticky", mem_err, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_clears_err", mem_err, 0);
    drv(1'b1, 12'h030, 2'b01, 4'd5, 8'h00, 8'h00, 1'b0, 8'h00); tick();
    idle(); tick();
    reset = 1'b1;
    drv(1'b1, 12'h031, 2'b00, 4'd6, 8'h44, 8'h00, 1'b1, 8'h99); tick();
    chk("rst_ld_en", rf_wr_en, 0); chk("rst_ld_stall", stall, 0);
    reset = 1'b0;
    drv(1'b1, 12'h000, 2'b00, 4'd1, 8'h21, 8'h00, 1'b0, 8'h00); tick();
    chk("post_rst_accept", rf_wr_en, 1);
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      drv($urandom_range(0, 3) != 0, 12'($urandom_range(0, 7)), 2'($urandom),
          4'($urandom), 8'($urandom), 8'($urandom),
          $urandom_range(0, 4) == 0, 8'($urandom));
      tick();
    end
    reset = 1'b1; idle(); tick(); reset = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      drv(1'b1, 12'(i), 2'b10, 4'(i), 8'h00, 8'(i), 1'b0, 8'h00); tick();
    end
    chk("wrap_ffff", wb_count, 16'hFFFF);
    drv(1'b1, 12'hABC, 2'b00, 4'd8, 8'h3C, 8'h00, 1'b0, 8'h00); tick();
    chk("wrap_zero", wb_count, 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
